// File: rtl/cam_cmd_sequencer.sv
// Command FIFO and issue FSM in front of the 8-entry x 4-bit associative register block.
// Optional hit/miss statistics are built when CAM_SEQ_STATS_EN is defined.
module cam_cmd_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_key,
    input  logic [3:0] cmd_new,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_hit,
    output logic [2:0] rsp_min,
    output logic [2:0] rsp_max,
    output logic [3:0] cam_key,
    output logic       cam_set,
    output logic [3:0] cam_new,
    output logic       cam_init,
    input  logic       cam_valid,
    input  logic [2:0] cam_min,
    input  logic [2:0] cam_max,
    output logic [7:0] stat_hits,
    output logic [7:0] stat_misses
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAT_W = 8;

    localparam logic [OP_W-1:0] OP_REPLACE = 2'b01;
    localparam logic [OP_W-1:0] OP_INIT    = 2'b10;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] nval;
    } cmd_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               boot_armed_q;

    cmd_t               mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               full_q;
    logic               empty;

    cmd_t               head;
    logic               head_init;
    logic               head_repl;
    logic               push;
    logic               issue;

    assign head      = mem[rd_ptr_q];
    assign head_init = (head.op == OP_INIT);
    assign head_repl = (head.op == OP_REPLACE);
    assign empty     = (count_q == '0);
    assign push      = cmd_valid && cmd_ready;

    // FSM state register; boot_armed delays the init pulse to the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            boot_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            boot_armed_q <= 1'b1;
        end
    end

    // Next state, issue decision and CAM drive from the FIFO head
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        cam_key   = '0;
        cam_set   = 1'b0;
        cam_new   = '0;
        cam_init  = 1'b0;

        case (state_q)
            BOOT: begin
                cam_init = boot_armed_q;
                if (boot_armed_q) begin
                    state_d = RUN;
                end
            end
            RUN, STALL: begin
                cmd_ready = !full_q;
                issue     = !empty && (!rsp_valid || rsp_ready);
                state_d   = (rsp_valid && !rsp_ready && !empty) ? STALL : RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (issue) begin
            if (head_init) begin
                cam_init = 1'b1;
            end else begin
                cam_key = head.key;
                if (head_repl) begin
                    cam_set = 1'b1;
                    cam_new = head.nval;
                end
            end
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push && !issue) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && issue) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointers and full flag; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // FIFO storage carries no reset; contents are only read below the valid occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{op: cmd_op, key: cmd_key, nval: cmd_new};
        end
    end

    // Response register; lookup results reflect CAM contents before a replace lands on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_min   <= '0;
            rsp_max   <= '0;
        end else if (issue) begin
            rsp_valid <= 1'b1;
            if (head_init) begin
                rsp_hit <= 1'b0;
                rsp_min <= '0;
                rsp_max <= '0;
            end else begin
                rsp_hit <= cam_valid;
                rsp_min <= IDX_W'(cam_min);
                rsp_max <= IDX_W'(cam_max);
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef CAM_SEQ_STATS_EN
    logic [STAT_W-1:0] hits_q;
    logic [STAT_W-1:0] misses_q;

    // Saturating hit/miss counters; an issued init clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (issue) begin
            if (head_init) begin
                hits_q   <= '0;
                misses_q <= '0;
            end else if (cam_valid) begin
                if (hits_q != '1) begin
                    hits_q <= hits_q + STAT_W'(1);
                end
            end else begin
                if (misses_q != '1) begin
                    misses_q <= misses_q + STAT_W'(1);
                end
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = STAT_W'(0);
    assign stat_misses = STAT_W'(0);
`endif

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Self-checking bench for cam_cmd_sequencer with a behavioural 8x4 CAM attached.
module tb_cam_cmd_sequencer;

    localparam int unsigned DEPTH = 4;

`ifdef CAM_SEQ_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_key;
    logic [3:0] cmd_new;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [2:0] rsp_min;
    logic [2:0] rsp_max;
    logic [3:0] cam_key;
    logic       cam_set;
    logic [3:0] cam_new;
    logic       cam_init;
    logic       cam_valid;
    logic [2:0] cam_min;
    logic [2:0] cam_max;
    logic [7:0] stat_hits;
    logic [7:0] stat_misses;

    always #5 clk = ~clk;

    cam_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_new(cmd_new),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_min(rsp_min), .rsp_max(rsp_max),
        .cam_key(cam_key), .cam_set(cam_set), .cam_new(cam_new), .cam_init(cam_init),
        .cam_valid(cam_valid), .cam_min(cam_min), .cam_max(cam_max),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    // Behavioural associative register block: init loads 8..F, replace rewrites every match
    logic [3:0] cmem [8];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (cam_init)                        cmem[i] <= 4'(8 + i);
            else if (cam_set && cmem[i] == cam_key) cmem[i] <= cam_new;
        end
    end
    always_comb begin
        cam_valid = 1'b0;
        cam_min   = 3'd0;
        cam_max   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cmem[i] == cam_key) begin
                if (!cam_valid) cam_min = 3'(i);
                cam_max   = 3'(i);
                cam_valid = 1'b1;
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] key;
        logic [3:0] nv;
        logic [6:0] exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         exp_hits = 0;
    int         exp_misses = 0;
    logic [6:0] sb_q [$];
    logic [6:0] drv_exp;
    vec_t       vecs [14];
    bit         acc;

    function automatic logic [6:0] r(input logic h, input int mn, input int mx);
        return {h, 3'(mn), 3'(mx)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_stats(input logic [1:0] op, input logic hit);
        if (op == 2'b10) begin
            exp_hits   = 0;
            exp_misses = 0;
        end else if (hit) begin
            if (exp_hits < 255) exp_hits++;
        end else begin
            if (exp_misses < 255) exp_misses++;
        end
    endtask

    // One clock: record an accepted command, score a taken response, advance to next negedge
    task automatic tick(output bit accepted);
        logic [6:0] e;
        accepted = cmd_valid && cmd_ready;
        if (accepted) begin
            sb_q.push_back(drv_exp);
            model_stats(cmd_op, drv_exp[6]);
        end
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("rsp_payload", 32'({rsp_hit, rsp_min, rsp_max}), 32'(e));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] key, input logic [3:0] nv,
                        input logic [6:0] exp);
        bit a;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        cmd_new   = nv;
        drv_exp   = exp;
        a = 1'b0;
        for (int n = 0; n < 50 && !a; n++) tick(a);
        check("cmd_accept", 32'(a), 32'(1));
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit a;
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) tick(a);
        check("drain_empty", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_stat_hits"},   32'(stat_hits),   STATS_ON ? 32'(exp_hits)   : 32'(0));
        check({tag, "_stat_misses"}, 32'(stat_misses), STATS_ON ? 32'(exp_misses) : 32'(0));
    endtask

    // Release reset at a negedge and verify the single BOOT init pulse
    task automatic boot_seq();
        rst_n = 1'b1;
        check("boot_init_pre", 32'(cam_init), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("boot_init_pulse", 32'(cam_init), 32'(1));
        check("boot_ready_low", 32'(cmd_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        check("boot_init_done", 32'(cam_init), 32'(0));
        check("boot_ready_high", 32'(cmd_ready), 32'(1));
        check("boot_rsp_valid", 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Hand-derived expectations; CAM starts as [8,9,A,B,C,D,E,F] after each init
        vecs[0]  = '{2'b00, 4'hA, 4'h0, r(1, 2, 2)};
        vecs[1]  = '{2'b01, 4'h9, 4'hA, r(1, 1, 1)};
        vecs[2]  = '{2'b00, 4'hA, 4'h0, r(1, 1, 2)};
        vecs[3]  = '{2'b00, 4'h3, 4'h0, r(0, 0, 0)};
        vecs[4]  = '{2'b11, 4'h8, 4'h5, r(1, 0, 0)};
        vecs[5]  = '{2'b01, 4'hF, 4'h8, r(1, 7, 7)};
        vecs[6]  = '{2'b00, 4'h8, 4'h0, r(1, 0, 7)};
        vecs[7]  = '{2'b01, 4'hA, 4'h3, r(1, 1, 2)};
        vecs[8]  = '{2'b00, 4'hA, 4'h0, r(0, 0, 0)};
        vecs[9]  = '{2'b00, 4'h3, 4'h0, r(1, 1, 2)};
        vecs[10] = '{2'b10, 4'h0, 4'h0, r(0, 0, 0)};
        vecs[11] = '{2'b00, 4'h9, 4'h0, r(1, 1, 1)};
        vecs[12] = '{2'b11, 4'hF, 4'h0, r(1, 7, 7)};
        vecs[13] = '{2'b00, 4'h0, 4'h0, r(0, 0, 0)};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_key   = 4'h0;
        cmd_new   = 4'h0;
        rsp_ready = 1'b0;
        drv_exp   = 7'd0;
        repeat (2) @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_fields", 32'({rsp_hit, rsp_min, rsp_max}), 32'(0));
        check("rst_cam_outs", 32'({cam_key, cam_set, cam_new, cam_init}), 32'(0));
        boot_seq();
        check_stats("boot");

        // Latency: enqueue at edge N, issue in cycle N+1, response valid after N+1
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_key   = 4'hA;
        drv_exp   = r(1, 2, 2);
        tick(acc);
        check("lat_accept", 32'(acc), 32'(1));
        cmd_valid = 1'b0;
        check("lat_issue_key", 32'(cam_key), 32'(4'hA));
        check("lat_issue_set", 32'(cam_set), 32'(0));
        check("lat_rsp_not_yet", 32'(rsp_valid), 32'(0));
        tick(acc);
        check("lat_rsp_valid", 32'(rsp_valid), 32'(1));
        tick(acc);
        check("lat_rsp_taken", 32'(rsp_valid), 32'(0));

        // Back-to-back table vectors with the consumer always ready
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].op, vecs[i].key, vecs[i].nv, vecs[i].exp);
        end
        drain();
        check_stats("table");

        // Backpressure: DEPTH+1 commands with rsp_ready low, then drain
        rsp_ready = 1'b0;
        send(2'b00, 4'hA, 4'h0, r(1, 2, 2));
        send(2'b00, 4'h3, 4'h0, r(0, 0, 0));
        send(2'b01, 4'h8, 4'h8, r(1, 0, 0));
        send(2'b00, 4'hF, 4'h0, r(1, 7, 7));
        send(2'b00, 4'hC, 4'h0, r(1, 4, 4));
        for (int k = 0; k < 3; k++) begin
            check("hold_ready_low", 32'(cmd_ready), 32'(0));
            check("hold_no_set", 32'(cam_set), 32'(0));
            check("hold_rsp", 32'({rsp_valid, rsp_hit, rsp_min, rsp_max}), 32'({1'b1, r(1, 2, 2)}));
            tick(acc);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            check("drain_rsp_valid", 32'(rsp_valid), 32'(1));
            tick(acc);
        end
        check("drain_done_valid", 32'(rsp_valid), 32'(0));
        check("drain_done_sb", 32'(sb_q.size()), 32'(0));
        check_stats("fill");

        // Mid-stream reset with three commands queued behind a held response
        rsp_ready = 1'b0;
        send(2'b00, 4'h8, 4'h0, r(1, 0, 0));
        send(2'b00, 4'h9, 4'h0, r(1, 1, 1));
        send(2'b00, 4'hA, 4'h0, r(1, 2, 2));
        send(2'b00, 4'hB, 4'h0, r(1, 3, 3));
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("async_rst_ready", 32'(cmd_ready), 32'(0));
        check("async_rst_cam", 32'({cam_key, cam_set, cam_init}), 32'(0));
        sb_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
        repeat (2) @(negedge clk);
        boot_seq();
        check_stats("reboot");
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("no_stale_rsp", 32'(rsp_valid), 32'(0));
            tick(acc);
        end
        send(2'b00, 4'hA, 4'h0, r(1, 2, 2));
        drain();
        check_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
